// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: op codes and FSM state encoding.
package muldiv_pkg;

  // Operation codes presented on op when start is asserted.
  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  // Sequencer states; busy is simply "not IDLE".
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_FIX  = 2'b11
  } state_e;

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and shift the quotient bit in.
// The quotient register doubles as the dividend shift register.
module div_iter #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvsr_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0]   part_s;
  logic [XLEN-1:0] diff_s;

  // Compare/subtract; rem_i < dvsr_i holds, so the difference fits in XLEN bits.
  always_comb begin
    part_s = {rem_i, quo_i[XLEN-1]};
    diff_s = part_s[XLEN-1:0] - dvsr_i;
    if (part_s >= {1'b0, dvsr_i}) begin
      rem_o = diff_s;
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o = part_s[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multiply/divide unit with HI/LO registers beside the EX-stage ALU.
// Multiply: product formed from the operands at acceptance, then carried
// through MUL_STAGES-1 register stages. Divide: one restoring step at
// acceptance plus XLEN-1 further steps, then a sign-fix cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic            div_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CNT_MAX = (XLEN > MUL_STAGES) ? XLEN : MUL_STAGES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PIPE_N  = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;
  localparam logic [XLEN-1:0]  ONE_X  = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};

  op_e               op_s;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic              done_q, done_d, dz_q, dz_d, busy_q;
  logic [XLEN-1:0]   rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic              negq_q, negq_d, negr_q, negr_d;

  logic [2*XLEN-1:0] mul_a_s, mul_b_s, prod_now_s, mul_res_s;
  logic [2*XLEN-1:0] pipe_q [PIPE_N];
  logic              a_neg_s, b_neg_s;
  logic [XLEN-1:0]   a_mag_s, b_mag_s;
  logic [XLEN-1:0]   st_rem_in_s, st_quo_in_s, st_dvsr_s, st_rem_s, st_quo_s;
  logic [XLEN-1:0]   fix_quo_s, fix_rem_s;

  assign op_s = op_e'(op);

  // Operand conditioning: sign extension for multiply, magnitudes for divide.
  always_comb begin
    mul_a_s    = {{XLEN{(op_s == OP_MULT) & rs_data[XLEN-1]}}, rs_data};
    mul_b_s    = {{XLEN{(op_s == OP_MULT) & rt_data[XLEN-1]}}, rt_data};
    prod_now_s = mul_a_s * mul_b_s;
    a_neg_s    = (op_s == OP_DIV) & rs_data[XLEN-1];
    b_neg_s    = (op_s == OP_DIV) & rt_data[XLEN-1];
    a_mag_s    = a_neg_s ? (~rs_data + ONE_X) : rs_data;
    b_mag_s    = b_neg_s ? (~rt_data + ONE_X) : rt_data;
    fix_quo_s  = negq_q ? (~quo_q + ONE_X) : quo_q;
    fix_rem_s  = negr_q ? (~rem_q + ONE_X) : rem_q;
  end

  // Product pipeline; free-running, sampled by the FSM at the right cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PIPE_N; i++) pipe_q[i] <= {(2*XLEN){1'b0}};
    end else begin
      pipe_q[0] <= prod_now_s;
      for (int i = 1; i < PIPE_N; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign mul_res_s = (MUL_STAGES == 1) ? prod_now_s : pipe_q[PIPE_N-1];

  // Divider step inputs: fresh magnitudes at acceptance, running state after.
  always_comb begin
    if (state_q == S_IDLE) begin
      st_rem_in_s = {XLEN{1'b0}};
      st_quo_in_s = a_mag_s;
      st_dvsr_s   = b_mag_s;
    end else begin
      st_rem_in_s = rem_q;
      st_quo_in_s = quo_q;
      st_dvsr_s   = dvsr_q;
    end
  end

  div_iter #(.XLEN(XLEN)) u_div_iter (
    .rem_i  (st_rem_in_s),
    .quo_i  (st_quo_in_s),
    .dvsr_i (st_dvsr_s),
    .rem_o  (st_rem_s),
    .quo_o  (st_quo_s)
  );

  // Next-state and HI/LO update logic; flush always beats completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          case (op_s)
            OP_MULT, OP_MULTU: begin
              if (MUL_STAGES == 1) begin
                hi_d   = mul_res_s[2*XLEN-1:XLEN];
                lo_d   = mul_res_s[XLEN-1:0];
                done_d = 1'b1;
              end else begin
                state_d = S_MUL;
                cnt_d   = CNT_W'(MUL_STAGES - 1);
              end
            end
            OP_DIV, OP_DIVU: begin
              if (rt_data == {XLEN{1'b0}}) begin
                hi_d   = rs_data;
                lo_d   = {XLEN{1'b1}};
                done_d = 1'b1;
                dz_d   = 1'b1;
              end else begin
                // First quotient bit is produced on the acceptance edge;
                // cnt counts the steps still to go.
                state_d = S_DIV;
                cnt_d   = CNT_W'(XLEN - 1);
                rem_d   = st_rem_s;
                quo_d   = st_quo_s;
                dvsr_d  = b_mag_s;
                negq_d  = a_neg_s ^ b_neg_s;
                negr_d  = a_neg_s;
              end
            end
            OP_MTHI: hi_d = rs_data;
            OP_MTLO: lo_d = rs_data;
            default: state_d = S_IDLE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == ONE_C) begin
          state_d = S_IDLE;
          hi_d    = mul_res_s[2*XLEN-1:XLEN];
          lo_d    = mul_res_s[XLEN-1:0];
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE_C;
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          rem_d   = st_rem_s;
          quo_d   = st_quo_s;
          cnt_d   = cnt_q - ONE_C;
          state_d = (cnt_q == ONE_C) ? S_FIX : S_DIV;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          hi_d   = fix_rem_s;
          lo_d   = fix_quo_s;
          done_d = 1'b1;
        end else begin
          done_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      hi_q    <= {XLEN{1'b0}};
      lo_q    <= {XLEN{1'b0}};
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      rem_q   <= {XLEN{1'b0}};
      quo_q   <= {XLEN{1'b0}};
      dvsr_q  <= {XLEN{1'b0}};
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      busy_q  <= (state_d != S_IDLE);
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
